// File: rtl/dl_pkg.sv
// ============================================================================
// Module      : dl_pkg
// Description : Shared range codes, scale constants, state type and the
//               range-code decoder for the launch-delay stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package dl_pkg;

    localparam int          MULT_W   = 17;
    localparam logic [4:0]  MLT_X1   = 5'd1;
    localparam logic [4:0]  MLT_X100 = 5'd2;

    localparam logic [MULT_W-1:0] SCALE_X1      = 17'd1;
    localparam logic [MULT_W-1:0] SCALE_X100    = 17'd100;
    localparam logic [MULT_W-1:0] SCALE_X100000 = 17'd100000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } dl_state_e;

    // Unrecognised codes fall into the widest range.
    function automatic logic [MULT_W-1:0] dl_mult_decode(input logic [4:0] code);
        logic [MULT_W-1:0] scale;
        case (code)
            MLT_X1:   scale = SCALE_X1;
            MLT_X100: scale = SCALE_X100;
            default:  scale = SCALE_X100000;
        endcase
        return scale;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dl_tick_counter.sv
// ============================================================================
// Module      : dl_tick_counter
// Description : Two-level countdown (cnt1 over D, cnt2 over M) flagging the
//               last cycle of a D*M interval.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dl_tick_counter #(
    parameter int DLY_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [DLY_W-1:0] i_d,
    input  logic [DLY_W-1:0] i_m,
    output logic             o_terminal
);
    import dl_pkg::*;

    logic [DLY_W-1:0] cnt1_q, cnt1_d;
    logic [DLY_W-1:0] cnt2_q, cnt2_d;
    logic             w_cnt1_wrap;

    // Only meaningful with D >= 1; D = 0 never reaches the counting state.
    assign w_cnt1_wrap = (i_d != '0) && (cnt1_q == i_d - 1'b1);
    assign o_terminal  = w_cnt1_wrap && (cnt2_q == i_m - 1'b1);

    always_comb begin
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        if (i_clr) begin
            cnt1_d = '0;
            cnt2_d = '0;
        end else if (i_en) begin
            if (w_cnt1_wrap) begin
                cnt1_d = '0;
                cnt2_d = cnt2_q + 1'b1;
            end else begin
                cnt1_d = cnt1_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/delay_launch.sv
// ============================================================================
// Module      : delay_launch
// Description : Programmable launch delay: waits D*M cycles after a rising
//               launch edge, then holds DL_out while DL_in stays high.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module delay_launch #(
    parameter int DLY_W = 17
) (
    input  logic             clk_DL,
    input  logic             rst_DL,
    input  logic             DL_en,
    input  logic             DL_in,
    input  logic [4:0]       dl_mlt,
    input  logic [DLY_W-1:0] delay,
    output logic             DL_out,
    output logic             DL_busy,
    output logic             DL_abort
);
    import dl_pkg::*;

    dl_state_e        state_q, state_d;
    logic             in_q;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             abort_q, abort_d;
    logic [DLY_W-1:0] d_lat_q, d_lat_d;
    logic [DLY_W-1:0] m_lat_q, m_lat_d;
    logic             w_rise;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_terminal;

    assign w_rise = DL_in & ~in_q;

    dl_tick_counter #(
        .DLY_W (DLY_W)
    ) u_tick_counter (
        .clk        (clk_DL),
        .rst        (rst_DL),
        .i_clr      (w_cnt_clr),
        .i_en       (w_cnt_en),
        .i_d        (d_lat_q),
        .i_m        (m_lat_q),
        .o_terminal (w_terminal)
    );

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        busy_d    = busy_q;
        abort_d   = 1'b0;
        d_lat_d   = d_lat_q;
        m_lat_d   = m_lat_q;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                out_d  = 1'b0;
                busy_d = 1'b0;
                if (DL_en && w_rise) begin
                    d_lat_d   = delay;
                    m_lat_d   = DLY_W'(dl_mult_decode(dl_mlt));
                    w_cnt_clr = 1'b1;
                    busy_d    = 1'b1;
                    // M is never zero, so N = 0 exactly when D = 0.
                    if (delay == '0) begin
                        state_d = ST_HOLD;
                        out_d   = 1'b1;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                if (!DL_en || !DL_in) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    abort_d   = 1'b1;
                    w_cnt_clr = 1'b1;
                end else if (w_terminal) begin
                    state_d = ST_HOLD;
                    out_d   = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!DL_en || !DL_in) begin
                    state_d = ST_IDLE;
                    out_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                out_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // in_q resets high so a launch level already present at reset is ignored.
    always_ff @(posedge clk_DL) begin
        if (rst_DL) begin
            state_q <= ST_IDLE;
            in_q    <= 1'b1;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
            d_lat_q <= '0;
            m_lat_q <= '0;
        end else begin
            state_q <= state_d;
            in_q    <= DL_in;
            out_q   <= out_d;
            busy_q  <= busy_d;
            abort_q <= abort_d;
            d_lat_q <= d_lat_d;
            m_lat_q <= m_lat_d;
        end
    end

    assign DL_out   = out_q;
    assign DL_busy  = busy_q;
    assign DL_abort = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_delay_launch.sv
// ============================================================================
// Module      : tb_delay_launch
// Description : Directed bench for delay_launch with hand-computed latencies.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_delay_launch;

    localparam int DLY_W = 17;

    logic             clk_DL = 1'b0;
    logic             rst_DL;
    logic             DL_en;
    logic             DL_in;
    logic [4:0]       dl_mlt;
    logic [DLY_W-1:0] delay;
    logic             DL_out;
    logic             DL_busy;
    logic             DL_abort;

    int errors = 0;
    int checks = 0;

    delay_launch #(.DLY_W(DLY_W)) dut (
        .clk_DL   (clk_DL),
        .rst_DL   (rst_DL),
        .DL_en    (DL_en),
        .DL_in    (DL_in),
        .dl_mlt   (dl_mlt),
        .delay    (delay),
        .DL_out   (DL_out),
        .DL_busy  (DL_busy),
        .DL_abort (DL_abort)
    );

    always #5 clk_DL = ~clk_DL;

    task automatic step(input int n);
        repeat (n) @(posedge clk_DL);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag, input logic o, input logic b, input logic a);
        check({tag, ".out"},   DL_out,   o);
        check({tag, ".busy"},  DL_busy,  b);
        check({tag, ".abort"}, DL_abort, a);
    endtask

    // Low-then-high on DL_in; returns 1 ns after E0.
    task automatic trig();
        DL_in = 1'b0;
        step(1);
        DL_in = 1'b1;
        step(1);
    endtask

    task automatic release_in();
        DL_in = 1'b0;
        step(1);
    endtask

    initial begin
        rst_DL = 1'b1;
        DL_en  = 1'b1;
        DL_in  = 1'b1;
        dl_mlt = 5'd1;
        delay  = 17'd5;
        step(2);
        check3("reset", 1'b0, 1'b0, 1'b0);
        rst_DL = 1'b0;
        step(5);
        check3("held_high_after_reset", 1'b0, 1'b0, 1'b0);

        // D=5 x1
        trig();
        check3("d5_e0", 1'b0, 1'b1, 1'b0);
        step(4);
        check("d5_e4.out", DL_out, 1'b0);
        step(1);
        check3("d5_e5", 1'b1, 1'b1, 1'b0);
        step(3);
        check("d5_hold.out", DL_out, 1'b1);
        release_in();
        check3("d5_fall", 1'b0, 1'b0, 1'b0);

        // D=0 fires at E0
        delay = 17'd0;
        trig();
        check3("d0_e0", 1'b1, 1'b1, 1'b0);
        release_in();
        check3("d0_fall", 1'b0, 1'b0, 1'b0);

        // D=3 x100 fires at E300
        delay  = 17'd3;
        dl_mlt = 5'd2;
        trig();
        step(299);
        check("d3x100_e299.out", DL_out, 1'b0);
        step(1);
        check("d3x100_e300.out", DL_out, 1'b1);
        release_in();

        // D=1 code 7 (x100000): still counting well past 100, then abort
        delay  = 17'd1;
        dl_mlt = 5'd7;
        trig();
        step(400);
        check3("d1x1e5_e400", 1'b0, 1'b1, 1'b0);
        release_in();
        check3("d1x1e5_abort", 1'b0, 1'b0, 1'b1);
        step(1);
        check("d1x1e5_abort_end", DL_abort, 1'b0);

        // D=20 dropped at E10, then clean retrigger
        delay  = 17'd20;
        dl_mlt = 5'd1;
        trig();
        step(9);
        DL_in = 1'b0;
        step(1);
        check3("d20_abort", 1'b0, 1'b0, 1'b1);
        step(1);
        check3("d20_idle", 1'b0, 1'b0, 1'b0);
        trig();
        step(19);
        check("d20_retrig_e19.out", DL_out, 1'b0);
        step(1);
        check("d20_retrig_e20.out", DL_out, 1'b1);
        release_in();

        // Settings changed mid-countdown are ignored until the next trigger
        delay = 17'd10;
        trig();
        step(4);
        delay  = 17'd2;
        dl_mlt = 5'd2;
        step(5);
        check("latch_e9.out", DL_out, 1'b0);
        step(1);
        check("latch_e10.out", DL_out, 1'b1);
        release_in();
        trig();
        step(199);
        check("latch_next_e199.out", DL_out, 1'b0);
        step(1);
        check("latch_next_e200.out", DL_out, 1'b1);
        release_in();

        // Enable dropped at E3 of D=8
        delay  = 17'd8;
        dl_mlt = 5'd1;
        trig();
        step(2);
        DL_en = 1'b0;
        step(1);
        check3("en_abort", 1'b0, 1'b0, 1'b1);
        step(1);
        check("en_abort_end", DL_abort, 1'b0);
        DL_en = 1'b1;
        trig();
        step(8);
        check3("en_hold", 1'b1, 1'b1, 1'b0);
        DL_en = 1'b0;
        step(1);
        check3("en_hold_drop", 1'b0, 1'b0, 1'b0);
        DL_en = 1'b1;
        step(2);
        check3("en_no_retrig", 1'b0, 1'b0, 1'b0);

        // Reset mid-countdown
        trig();
        step(3);
        rst_DL = 1'b1;
        step(1);
        check3("mid_reset", 1'b0, 1'b0, 1'b0);
        rst_DL = 1'b0;
        step(10);
        check3("post_reset_held", 1'b0, 1'b0, 1'b0);
        trig();
        step(8);
        check3("post_reset_launch", 1'b1, 1'b1, 1'b0);
        release_in();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
